// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: arctangent table in turn units,
// inverse CORDIC gain and the controller state type.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT,
    ST_FIN,
    ST_DONE
  } cordic_state_t;

  // 1/K for the infinite-iteration CORDIC gain, Q0.32.
  localparam logic [31:0] INV_GAIN = 32'h9B74EDA8;

  // round(atan(2^-i) / (2*pi) * 2^40)
  localparam logic [63:0] ATAN40 [40] = '{
    64'd137438953472, 64'd81134951838,  64'd42869480287,  64'd21761217566,
    64'd10922836750,  64'd5466743129,   64'd2734038620,   64'd1367102738,
    64'd683561799,    64'd341782203,    64'd170891265,    64'd85445653,
    64'd42722829,     64'd21361415,     64'd10680707,     64'd5340354,
    64'd2670177,      64'd1335088,      64'd667544,       64'd333772,
    64'd166886,       64'd83443,        64'd41722,        64'd20861,
    64'd10430,        64'd5215,         64'd2608,         64'd1304,
    64'd652,          64'd326,          64'd163,          64'd81,
    64'd41,           64'd20,           64'd10,           64'd5,
    64'd3,            64'd1,            64'd1,            64'd0
  };

  // Table entry rounded to an accumulator where 2^zw is one full turn.
  function automatic logic [63:0] atan_entry(input logic [5:0] i, input int unsigned zw);
    return (ATAN40[i] + (64'd1 << (39 - zw))) >> (40 - zw);
  endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One vectoring-mode micro-rotation: drives y toward zero and accumulates the
// rotated angle. Purely combinational; reused for every iteration.
module cordic_micro_rotation #(
  parameter int unsigned XW = 18,
  parameter int unsigned ZW = 19,
  parameter int unsigned SW = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic        [ZW-1:0] z_i,
  input  logic        [SW-1:0] shift_i,
  input  logic        [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic        [ZW-1:0] z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    if (y_i[XW-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_phase_mag.sv
// Iterative vectoring CORDIC: (x, y) -> phase in 2^WIDTH-per-turn code.
// Define CORDIC_PHASE_MAG_MAGNITUDE_EN to also produce gain-compensated magnitude.
module cordic_phase_mag
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_x,
  input  logic signed [WIDTH-1:0] s_y,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic        [WIDTH-1:0] m_phase,
  output logic        [WIDTH-1:0] m_mag
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned ZW = WIDTH + 3;
  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  cordic_state_t        state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic        [ZW-1:0] z_q, z_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic     [WIDTH-1:0] phase_q, phase_d;

  logic signed [XW-1:0] sx_ext, sy_ext, x_rot, y_rot;
  logic        [ZW-1:0] z_rot, atan_i, z_rnd;

  assign sx_ext = {{2{s_x[WIDTH-1]}}, s_x};
  assign sy_ext = {{2{s_y[WIDTH-1]}}, s_y};
  assign atan_i = ZW'(atan_entry(6'(cnt_q), ZW));
  assign z_rnd  = z_q + ZW'(4);

  cordic_micro_rotation #(
    .XW(XW),
    .ZW(ZW),
    .SW(CW)
  ) u_rot (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .shift_i(cnt_q),
    .atan_i (atan_i),
    .x_o    (x_rot),
    .y_o    (y_rot),
    .z_o    (z_rot)
  );

`ifdef CORDIC_PHASE_MAG_MAGNITUDE_EN
  localparam int unsigned PW = XW + 32;
  logic             fin2_q, fin2_d;
  logic [WIDTH-1:0] magc_q, magc_d, mag_q, mag_d;
  logic [PW-1:0]    prod;
  logic [XW-1:0]    mag_full;
  logic [WIDTH-1:0] mag_sat;

  // x is non-negative after the pre-fold, so it is scaled as unsigned.
  always_comb begin
    prod     = PW'($unsigned(x_q)) * PW'(INV_GAIN) + (PW'(1) << 31);
    mag_full = XW'(prod >> 32);
    mag_sat  = (|mag_full[XW-1:WIDTH]) ? '1 : mag_full[WIDTH-1:0];
  end
  assign m_mag = mag_q;
`else
  assign m_mag = '0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    phase_d = phase_q;
`ifdef CORDIC_PHASE_MAG_MAGNITUDE_EN
    fin2_d  = fin2_q;
    magc_d  = magc_q;
    mag_d   = mag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          zero_d  = (s_x == '0) && (s_y == '0);
          cnt_d   = '0;
          state_d = ST_ROT;
          // Left half-plane: rotate by half a turn so CORDIC convergence holds.
          if (s_x[WIDTH-1]) begin
            x_d = -sx_ext;
            y_d = -sy_ext;
            z_d = {1'b1, {(ZW-1){1'b0}}};
          end else begin
            x_d = sx_ext;
            y_d = sy_ext;
            z_d = '0;
          end
        end
      end
      ST_ROT: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIN;
      end
      ST_FIN: begin
`ifdef CORDIC_PHASE_MAG_MAGNITUDE_EN
        if (!fin2_q) begin
          magc_d = mag_sat;
          fin2_d = 1'b1;
        end else begin
          phase_d = zero_q ? '0 : WIDTH'(z_rnd >> 3);
          mag_d   = zero_q ? '0 : magc_q;
          fin2_d  = 1'b0;
          state_d = ST_DONE;
        end
`else
        phase_d = zero_q ? '0 : WIDTH'(z_rnd >> 3);
        state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      phase_q <= '0;
`ifdef CORDIC_PHASE_MAG_MAGNITUDE_EN
      fin2_q  <= 1'b0;
      magc_q  <= '0;
      mag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      phase_q <= phase_d;
`ifdef CORDIC_PHASE_MAG_MAGNITUDE_EN
      fin2_q  <= fin2_d;
      magc_q  <= magc_d;
      mag_q   <= mag_d;
`endif
    end
  end

  assign s_ready = (state_q == ST_IDLE);
  assign m_valid = (state_q == ST_DONE);
  assign m_phase = phase_q;

endmodule

// File: tb/tb_cordic_phase_mag.sv
// Randomized self-checking bench for cordic_phase_mag against an atan2/sqrt model.
module tb_cordic_phase_mag;

  localparam int  W  = 16;
  localparam int  IT = 16;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_PHASE_MAG_MAGNITUDE_EN
  localparam int LAT    = IT + 2;
  localparam bit MAG_EN = 1'b1;
`else
  localparam int LAT    = IT + 1;
  localparam bit MAG_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_x;
  logic signed [W-1:0] s_y;
  logic                m_valid;
  logic                m_ready;
  logic        [W-1:0] m_phase;
  logic        [W-1:0] m_mag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_phase_mag #(
    .WIDTH(W),
    .ITER (IT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_x    (s_x),
    .s_y    (s_y),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_phase(m_phase),
    .m_mag  (m_mag)
  );

  task automatic check(input string tag, input int got, input int exp, input int tol, input bit circ);
    int d;
    logic signed [15:0] ds;
    n_checks++;
    if (circ) begin
      ds = 16'(got - exp);
      d  = ds;
    end else begin
      d = got - exp;
    end
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int ref_phase(input int x, input int y);
    real a;
    a = $atan2(real'(y), real'(x)) / (2.0 * PI) * 65536.0;
    if (a < 0.0) a = a + 65536.0;
    return rnd(a) % 65536;
  endfunction

  function automatic int ref_mag(input int x, input int y);
    return rnd($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
  endfunction

  task automatic run_op(input int x, input int y, output int ph, output int mg, output int lat);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_x = 16'(x);
    s_y = 16'(y);
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", int'(s_ready), 1, 0, 1'b0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_x = 16'($urandom);
    s_y = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!m_valid && lat < 200);
    check("result_valid", int'(m_valid), 1, 0, 1'b0);
    ph = int'(m_phase);
    mg = int'(m_mag);
  endtask

  task automatic take();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic check_mag(input string tag, input int mg, input int exp, input int tol);
    if (MAG_EN) check(tag, mg, exp, tol, 1'b0);
    else        check(tag, mg, 0, 0, 1'b0);
  endtask

  int dx [9] = '{32767, 0,     -32767, 0,      10000, 10000, -32768, -32768, 12345};
  int dy [9] = '{0,     32767, 0,      -32767, 10000, -1,    -1,     -32768, -23456};
  int de [9] = '{0,     16384, 32768,  49152,  8192,  0,     32768,  40960,  0};

  initial begin
    int ph, mg, lat, x, y, a, hits;

    reset_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_x     = '0;
    s_y     = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", int'(s_ready), 1, 0, 1'b0);
    check("rst_m_valid", int'(m_valid), 0, 0, 1'b0);
    check("rst_m_phase", int'(m_phase), 0, 0, 1'b0);
    check("rst_m_mag",   int'(m_mag),   0, 0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", int'(s_ready), 1, 0, 1'b0);

    // Directed axis, diagonal and wrap points.
    de[8] = ref_phase(dx[8], dy[8]);
    for (int i = 0; i < 9; i++) begin
      run_op(dx[i], dy[i], ph, mg, lat);
      check("dir_phase", ph, de[i], 1, 1'b1);
      check_mag("dir_mag", mg, ref_mag(dx[i], dy[i]), 3);
      if (i == 0) check("latency", lat, LAT, 0, 1'b0);
      take();
    end

    // Zero input.
    run_op(0, 0, ph, mg, lat);
    check("zero_phase", ph, 0, 0, 1'b0);
    check("zero_mag", mg, 0, 0, 1'b0);
    check("zero_latency", lat, LAT, 0, 1'b0);
    take();

    // Backpressure: result held while m_ready is low.
    run_op(0, 32767, ph, mg, lat);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_m_valid", int'(m_valid), 1, 0, 1'b0);
      check("bp_s_ready", int'(s_ready), 0, 0, 1'b0);
      check("bp_phase", int'(m_phase), 16384, 1, 1'b1);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", int'(m_valid), 0, 0, 1'b0);
    check("bp_release_ready", int'(s_ready), 1, 0, 1'b0);

    // Reset in the middle of the rotations aborts the operation.
    s_valid = 1'b1;
    s_x = 16'sd0;
    s_y = 16'sd32767;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_s_ready", int'(s_ready), 1, 0, 1'b0);
    check("midrst_m_valid", int'(m_valid), 0, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    hits = 0;
    for (int c = 0; c < IT + 5; c++) begin
      @(negedge clk);
      if (m_valid) hits++;
    end
    check("midrst_no_result", hits, 0, 0, 1'b0);
    check("midrst_s_ready_after", int'(s_ready), 1, 0, 1'b0);
    run_op(0, 32767, ph, mg, lat);
    check("midrst_next_phase", ph, 16384, 1, 1'b1);
    take();

    // Random pairs with max(|x|,|y|) >= 2^14.
    for (int k = 0; k < 300; k++) begin
      do begin
        x = int'($urandom_range(0, 65535)) - 32768;
        y = int'($urandom_range(0, 65535)) - 32768;
      end while ((x < 16384 && x > -16384) && (y < 16384 && y > -16384));
      run_op(x, y, ph, mg, lat);
      check("rand_phase", ph, ref_phase(x, y), 2, 1'b1);
      check_mag("rand_mag", mg, ref_mag(x, y), 3);
      take();
    end

    // Random points on the full-scale circle: phase must recover the angle.
    for (int k = 0; k < 512; k++) begin
      a = int'($urandom_range(0, 65535));
      x = rnd(32767.0 * $cos(2.0 * PI * real'(a) / 65536.0));
      y = rnd(32767.0 * $sin(2.0 * PI * real'(a) / 65536.0));
      run_op(x, y, ph, mg, lat);
      check("sweep_phase", ph, a, 2, 1'b1);
      check_mag("sweep_mag", mg, 32767, 2);
      take();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
